// File: rtl/adsr_pkg.sv
// Shared state encoding and default envelope parameters for adsr_envelope.
package adsr_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int DEF_TICK_DIV      = 100000;
  localparam int DEF_ATTACK_STEP   = 8;
  localparam int DEF_DECAY_STEP    = 2;
  localparam int DEF_SUSTAIN_LEVEL = 160;
  localparam int DEF_RELEASE_STEP  = 1;

  // Clamp an integer parameter into the 8-bit envelope range.
  function automatic logic [7:0] sat8(input int v);
    if (v > 255) return 8'hFF;
    if (v < 0)   return 8'h00;
    return v[7:0];
  endfunction
endpackage

// File: rtl/env_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, never resynchronised.
module env_tick_gen
  import adsr_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);
  assign cnt_d  = tick_o ? RELOAD : cnt_q - 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope with saturating env arithmetic and sample scaling.
// Define ADSR_RETRIGGER_EN to let a retrig pulse restart ATTACK while gate is held.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int ATTACK_STEP   = DEF_ATTACK_STEP,
  parameter int DECAY_STEP    = DEF_DECAY_STEP,
  parameter int SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
  parameter int RELEASE_STEP  = DEF_RELEASE_STEP
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       gate,
  input  logic       retrig,
  input  logic [7:0] sample_in,
  output logic [7:0] level_out,
  output logic [7:0] env,
  output logic       active
);
  localparam logic [9:0] A_STEP = 10'(ATTACK_STEP);
  localparam logic [9:0] D_STEP = 10'(DECAY_STEP);
  localparam logic [9:0] R_STEP = 10'(RELEASE_STEP);
  localparam logic [7:0] SUS    = sat8(SUSTAIN_LEVEL);

  logic [2:0]  state_q, state_d;
  logic [7:0]  env_q, env_d;
  logic [7:0]  level_q, level_d;
  logic        tick, retrig_hit;
  logic [9:0]  att_sum, env_ext;
  logic signed [9:0] dec_dif;
  logic [16:0] prod;
  logic        unused_prod;

  env_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i (CLK100MHZ),
    .rst_i (reset),
    .tick_o(tick)
  );

`ifdef ADSR_RETRIGGER_EN
  assign retrig_hit = retrig & gate;
`else
  logic unused_retrig;
  assign unused_retrig = retrig;
  assign retrig_hit    = 1'b0;
`endif

  assign env_ext = {2'b00, env_q};
  assign att_sum = env_ext + A_STEP;
  assign dec_dif = $signed(env_ext) - $signed(D_STEP);

  // Gate transitions and retrig take the cycle; env only moves on an otherwise quiet tick.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    case (state_q)
      ST_IDLE: begin
        env_d = '0;
        if (gate) begin
          state_d = ST_ATTACK;
          env_d   = env_q;
        end
      end
      ST_ATTACK: begin
        if (!gate)          state_d = ST_RELEASE;
        else if (retrig_hit) state_d = ST_ATTACK;
        else if (tick) begin
          if (att_sum >= 10'd255) begin
            env_d   = 8'hFF;
            state_d = ST_DECAY;
          end else env_d = att_sum[7:0];
        end
      end
      ST_DECAY: begin
        if (!gate)          state_d = ST_RELEASE;
        else if (retrig_hit) state_d = ST_ATTACK;
        else if (tick) begin
          if (dec_dif <= $signed({2'b00, SUS})) begin
            env_d   = SUS;
            state_d = ST_SUSTAIN;
          end else env_d = dec_dif[7:0];
        end
      end
      ST_SUSTAIN: begin
        if (!gate)          state_d = ST_RELEASE;
        else if (retrig_hit) state_d = ST_ATTACK;
      end
      ST_RELEASE: begin
        if (gate) state_d = ST_ATTACK;
        else if (tick) begin
          if (env_ext <= R_STEP) begin
            env_d   = '0;
            state_d = ST_IDLE;
          end else env_d = env_q - R_STEP[7:0];
        end
      end
      default: begin
        state_d = ST_IDLE;
        env_d   = '0;
      end
    endcase
  end

  // env+1 makes env=255 an exact pass-through after the >>8.
  assign prod        = 17'(sample_in) * 17'({1'b0, env_q} + 9'd1);
  assign unused_prod = prod[16];
  assign level_d     = (state_q == ST_IDLE) ? 8'h00 : prod[15:8];

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      level_q <= level_d;
    end
  end

  assign env       = env_q;
  assign level_out = level_q;
  assign active    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed table, corner sequences, random run vs reference model.
module tb_adsr_envelope;
  localparam int TD = 4;
`ifdef ADSR_RETRIGGER_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, gate = 1'b0, retrig = 1'b0;
  logic [7:0] sample = 8'd0;
  logic [7:0] level_out, env;
  logic active;

  int checks = 0, errors = 0;

  adsr_envelope #(.TICK_DIV(TD)) dut (
    .CLK100MHZ(clk), .reset(rst), .gate(gate), .retrig(retrig),
    .sample_in(sample), .level_out(level_out), .env(env), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: phase names and plain integer envelope rules.
  typedef enum int {M_IDLE, M_ATT, M_DEC, M_SUS, M_REL} mph_t;
  mph_t m_ph;
  int   m_env, m_lvl, m_k;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= M_IDLE; m_env <= 0; m_lvl <= 0; m_k <= 0;
    end else begin : upd
      mph_t ph;
      int   e;
      bit   held, tk;
      ph   = m_ph;
      e    = m_env;
      held = (ph == M_ATT) || (ph == M_DEC) || (ph == M_SUS);
      tk   = (m_k % TD) == TD - 1;
      m_lvl <= (ph == M_IDLE) ? 0 : (int'(sample) * (e + 1)) / 256;
      if (!held && gate)               ph = M_ATT;
      else if (held && !gate)          ph = M_REL;
      else if (RT && held && retrig)   ph = M_ATT;
      else if (tk) begin
        case (ph)
          M_ATT: begin e = e + 8; if (e >= 255) begin e = 255; ph = M_DEC; end end
          M_DEC: begin e = e - 2; if (e <= 160) begin e = 160; ph = M_SUS; end end
          M_REL: begin if (e <= 1) begin e = 0; ph = M_IDLE; end else e = e - 1; end
          default: ;
        endcase
      end
      m_ph  <= ph;
      m_env <= e;
      m_k   <= m_k + 1;
    end
  end

  typedef struct {
    logic g;
    int   n;
    int   e_env;
    logic e_act;
    int   e_lvl;
  } vec_t;
  vec_t tbl[16];

  initial begin
    // Full note with sample_in=200; n is clocks to run after applying g.
    tbl[0]  = '{1'b1,   1,   0, 1'b1,   0};
    tbl[1]  = '{1'b1,   3,   8, 1'b1,   0};
    tbl[2]  = '{1'b1, 120, 248, 1'b1, 188};
    tbl[3]  = '{1'b1,   4, 255, 1'b1, 194};
    tbl[4]  = '{1'b1,   1, 255, 1'b1, 200};
    tbl[5]  = '{1'b1, 191, 160, 1'b1, 126};
    tbl[6]  = '{1'b1,   1, 160, 1'b1, 125};
    tbl[7]  = '{1'b1,  20, 160, 1'b1, 125};
    tbl[8]  = '{1'b0,   1, 160, 1'b1, 125};
    tbl[9]  = '{1'b0,   2, 159, 1'b1, 125};
    tbl[10] = '{1'b0, 276,  90, 1'b1,  71};
    tbl[11] = '{1'b1,   1,  90, 1'b1,  71};
    tbl[12] = '{1'b1,   3,  98, 1'b1,  71};
    tbl[13] = '{1'b0,   1,  98, 1'b1,  77};
    tbl[14] = '{1'b0, 391,   0, 1'b0,   1};
    tbl[15] = '{1'b0,   1,   0, 1'b0,   0};

    repeat (2) @(negedge clk);
    chk("reset_env",    int'(env),       0);
    chk("reset_level",  int'(level_out), 0);
    chk("reset_active", int'(active),    0);

    rst    = 1'b0;
    sample = 8'd200;
    for (int i = 0; i < 16; i++) begin
      gate = tbl[i].g;
      repeat (tbl[i].n) @(negedge clk);
      chk($sformatf("tbl%0d_env", i),    int'(env),       tbl[i].e_env);
      chk($sformatf("tbl%0d_active", i), int'(active),    int'(tbl[i].e_act));
      chk($sformatf("tbl%0d_level", i),  int'(level_out), tbl[i].e_lvl);
    end

    // Retrigger from SUSTAIN; the retrig clock lands two clocks before a tick.
    gate = 1'b1;
    repeat (400) @(negedge clk);
    chk("rt_sustain_env", int'(env), 160);
    retrig = 1'b1;
    @(negedge clk);
    retrig = 1'b0;
    chk("rt_hold_env", int'(env), 160);
    repeat (2) @(negedge clk);
    chk("rt_tick_env", int'(env), RT ? 168 : 160);
    chk("rt_active",   int'(active), 1);

    // Asynchronous reset mid-attack.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (32) @(negedge clk);
    chk("mid_attack_env", int'(env), 64);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_env",    int'(env),       0);
    chk("async_rst_level",  int'(level_out), 0);
    chk("async_rst_active", int'(active),    0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("resume_env",    int'(env),    8);
    chk("resume_active", int'(active), 1);

    // Random run against the reference model.
    rst  = 1'b1;
    gate = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      chk("rnd_env",    int'(env),       m_env);
      chk("rnd_level",  int'(level_out), m_lvl);
      chk("rnd_active", int'(active),    int'(m_ph != M_IDLE));
      if ($urandom_range(0, 299) == 0) gate = ~gate;
      retrig = ($urandom_range(0, 39) == 0);
      sample = 8'($urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
